trace_reader: RTL and testbench
===============================

// Module: trace_reader
// PURPOSE
//  Reads the TDC trace buffer back out. The tracer fills the buffer with 8-bit samples.
//  This block fetches them through the BRAM read port and packs sample pairs into 16-bit words.
//  It presents one word at a time to the local-bus interface using a prefetch/consume handshake.
//  Sits between the trace BRAM read port and the LBUS_IF read-data mux, in the clk domain.
// PARAMETERS
//  ADDR_W   13  trace buffer address width; pointer wraps modulo 2**ADDR_W
//  SMP_W    8   sample width; rd_data is 2*SMP_W
//  MEM_LAT  1   BRAM read latency in cycles (1 or 2)
// PORTS
//  clk          in   1         system clock (MMCM CLKOUT0 via BUFG)
//  rstn         in   1         asynchronous active-low reset
//  arm          in   1         1-cycle pulse: load start_addr/len and begin readout
//  start_addr   in   ADDR_W    first sample address; bit0 ignored (word aligned)
//  len          in   ADDR_W    number of 16-bit words to read; 0 = nothing
//  rd_req       in   1         1-cycle pulse: host consumes the current word
//  rd_data      out  2*SMP_W   current word; [SMP_W-1:0] = even (earlier) sample
//  rd_vld       out  1         rd_data holds an unconsumed word
//  busy         out  1         readout in progress (words remaining or fetch in flight)
//  underrun     out  1         sticky: rd_req seen while rd_vld=0; cleared by arm
//  mem_rd_en    out  1         BRAM read enable
//  mem_rd_addr  out  ADDR_W    BRAM read address
//  mem_rd_data  in   SMP_W     BRAM read data, valid MEM_LAT cycles after mem_rd_en
//  chksum       out  2*SMP_W   running XOR of consumed words (see CONFIGURATION)
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, ptr=0, remaining=0, no fetch in flight.
//  FSM: IDLE -> ISSUE_LO -> ISSUE_HI -> WAIT -> HOLD -> (ISSUE_LO | IDLE).
//   ISSUE_LO: mem_rd_en=1, addr=ptr. ISSUE_HI: mem_rd_en=1, addr=ptr+1 (mod 2**ADDR_W).
//   WAIT: low byte captured MEM_LAT cycles after ISSUE_LO, high byte MEM_LAT cycles after ISSUE_HI.
//     On high-byte capture: rd_vld<=1, ptr<=ptr+2, remaining<=remaining-1; go to HOLD.
//   HOLD: rd_req -> rd_vld<=0; then ISSUE_LO if remaining>0, else IDLE.
//  Latency: arm in cycle a -> rd_vld high from cycle a+MEM_LAT+3.
//    rd_req in cycle c -> rd_vld low in c+1; next word valid from c+MEM_LAT+3.
//  Clamp: len > 2**(ADDR_W-1) is clamped to 2**(ADDR_W-1), i.e. one full buffer.
//  arm with len=0: ptr loaded, underrun cleared, stays IDLE, busy=0, rd_vld=0.
//  busy = (state!=IDLE); it falls in the cycle after the last word is consumed.
//  Wrap: ptr rolls from 2**ADDR_W-2 to 0 without a gap.
//  rd_req with rd_vld=0: ignored for data, sets underrun; FSM unaffected.
//  arm has priority over rd_req in the same cycle. arm in any state:
//    aborts the current fetch and discards in-flight BRAM returns (no stale capture).
//    Clears rd_vld and underrun, then restarts from ISSUE_LO next cycle.
//  mem_rd_en is never asserted in IDLE or HOLD. At most 2 reads are outstanding.
//  rd_data holds its value while rd_vld=1 and is undefined-but-stable otherwise (keep last).
//  Reset mid-operation: immediate return to reset values; pending returns ignored.
// CONFIGURATION
//  TRACE_RD_CHKSUM_EN defined:
//    chksum <= chksum ^ rd_data on every accepted rd_req (rd_vld=1); cleared by arm and reset.
//  TRACE_RD_CHKSUM_EN undefined: chksum tied to 0; no checksum register is synthesised.
// TESTING
//  Setup: BRAM model with mem[i]=i[7:0]; MEM_LAT=1 and 2 runs.
//  1. arm, start_addr=0x0010, len=3, rd_req each time rd_vld=1:
//     words 0x1110, 0x1312, 0x1514; busy falls after 3rd; rd_vld up 4 cycles after arm (LAT=1).
//  2. arm, start_addr=0x1FFE, len=2: words 0xFFFE then 0x0100 (wrap), no extra mem_rd_en.
//  3. rd_req while rd_vld=0 after reset -> underrun=1, rd_data=0, no mem_rd_en.
//     A subsequent arm clears underrun.
//  4. arm, len=4; re-arm with start_addr=0x0040, len=1 during ISSUE_HI of word 1:
//     only 0x4140 delivered, stale bytes never appear.
//  5. rstn low for 1 cycle mid-WAIT: all outputs 0, state IDLE; next arm works normally.
//  6. TRACE_RD_CHKSUM_EN: test 1 stimulus -> chksum = 0x1110^0x1312^0x1514 = 0x1716.
//     Without the macro, chksum stays 0.

Source files
------------

// File: rtl/trace_reader.sv
// trace_reader: reads 8-bit trace samples from BRAM, packs pairs into 16-bit words
// and hands them out one at a time with a prefetch/consume handshake.
// Ports:
//   clk, rstn (async, active low)
//   arm, start_addr, len       - load a readout and start it
//   rd_req, rd_data, rd_vld    - host consume handshake
//   busy, underrun             - status (underrun sticky until arm)
//   mem_rd_en/addr/data        - BRAM read port, data MEM_LAT cycles after enable
//   chksum                     - XOR of consumed words
// Build option: TRACE_RD_CHKSUM_EN enables the checksum register.
module trace_reader #(
  parameter int ADDR_W  = 13,
  parameter int SMP_W   = 8,
  parameter int MEM_LAT = 1
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                arm,
  input  logic [ADDR_W-1:0]   start_addr,
  input  logic [ADDR_W-1:0]   len,
  input  logic                rd_req,
  output logic [2*SMP_W-1:0]  rd_data,
  output logic                rd_vld,
  output logic                busy,
  output logic                underrun,
  output logic                mem_rd_en,
  output logic [ADDR_W-1:0]   mem_rd_addr,
  input  logic [SMP_W-1:0]    mem_rd_data,
  output logic [2*SMP_W-1:0]  chksum
);

  typedef enum logic [2:0] {
    IDLE, ISSUE_LO, ISSUE_HI, WAIT, HOLD
  } state_t;

  localparam logic [ADDR_W-1:0] LEN_MAX =
    {1'b1, {(ADDR_W-1){1'b0}}};

  state_t              state, state_nx;
  logic [ADDR_W-1:0]   ptr;
  logic [ADDR_W-1:0]   remaining;
  logic [ADDR_W-1:0]   len_eff;
  logic [SMP_W-1:0]    lo_byte;
  // Tags travelling alongside the BRAM pipeline; cleared on arm
  // so returns of aborted reads are never captured.
  logic [MEM_LAT-1:0]  lo_pipe, hi_pipe;
  logic                lo_ret, hi_ret;
  logic                accept;
  logic                unused_bit0;

  assign unused_bit0 = start_addr[0];
  assign lo_ret  = lo_pipe[MEM_LAT-1];
  assign hi_ret  = hi_pipe[MEM_LAT-1];
  assign accept  = rd_req & rd_vld & ~arm;
  assign len_eff = (len > LEN_MAX) ? LEN_MAX : len;
  assign busy    = (state != IDLE);

  always_comb begin
    state_nx    = state;
    mem_rd_en   = 1'b0;
    mem_rd_addr = '0;
    case (state)
      IDLE: ;
      ISSUE_LO: begin
        mem_rd_en   = 1'b1;
        mem_rd_addr = ptr;
        state_nx    = ISSUE_HI;
      end
      ISSUE_HI: begin
        mem_rd_en   = 1'b1;
        mem_rd_addr = ptr + ADDR_W'(1);
        state_nx    = WAIT;
      end
      WAIT: begin
        if (hi_ret) state_nx = HOLD;
      end
      HOLD: begin
        if (accept)
          state_nx = (remaining != '0) ? ISSUE_LO : IDLE;
      end
      default: state_nx = IDLE;
    endcase
    if (arm)
      state_nx = (len == '0) ? IDLE : ISSUE_LO;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      ptr       <= '0;
      remaining <= '0;
      lo_byte   <= '0;
      lo_pipe   <= '0;
      hi_pipe   <= '0;
      rd_data   <= '0;
      rd_vld    <= 1'b0;
      underrun  <= 1'b0;
    end else begin
      state   <= state_nx;
      lo_pipe <= (lo_pipe << 1) | MEM_LAT'(state == ISSUE_LO);
      hi_pipe <= (hi_pipe << 1) | MEM_LAT'(state == ISSUE_HI);
      if (arm) begin
        ptr       <= {start_addr[ADDR_W-1:1], 1'b0};
        remaining <= len_eff;
        rd_vld    <= 1'b0;
        underrun  <= 1'b0;
        lo_pipe   <= '0;
        hi_pipe   <= '0;
      end else begin
        if (lo_ret) lo_byte <= mem_rd_data;
        if (hi_ret) begin
          rd_data   <= {mem_rd_data, lo_byte};
          rd_vld    <= 1'b1;
          ptr       <= ptr + ADDR_W'(2);
          remaining <= remaining - ADDR_W'(1);
        end
        if (rd_req) begin
          if (rd_vld) rd_vld   <= 1'b0;
          else        underrun <= 1'b1;
        end
      end
    end
  end

`ifdef TRACE_RD_CHKSUM_EN
  logic [2*SMP_W-1:0] chk_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)       chk_q <= '0;
    else if (arm)    chk_q <= '0;
    else if (accept) chk_q <= chk_q ^ rd_data;
  end

  assign chksum = chk_q;
`else
  assign chksum = '0;
`endif

endmodule

// File: tb/tb_trace_reader.sv
// tb_trace_reader: randomized + directed bench for trace_reader,
// one DUT with MEM_LAT=1 and one with MEM_LAT=2.
module tb_trace_reader;

  logic        clk = 1'b0;
  logic        rstn;
  logic        arm [2];
  logic [12:0] start_addr [2];
  logic [12:0] len [2];
  logic        rd_req [2];
  logic [15:0] rd_data [2];
  logic        rd_vld [2];
  logic        busy [2];
  logic        underrun [2];
  logic        mem_rd_en [2];
  logic [12:0] mem_rd_addr [2];
  logic [7:0]  mem_rd_data [2];
  logic [15:0] chksum [2];
  int          en_cnt [2];
  logic [7:0]  memv [8192];
  int          n_cmp = 0;
  int          n_bad = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic [7:0] q1, q2;
    int         cnt;

    trace_reader #(.MEM_LAT(g + 1)) u_dut (
      .clk(clk), .rstn(rstn), .arm(arm[g]),
      .start_addr(start_addr[g]), .len(len[g]),
      .rd_req(rd_req[g]), .rd_data(rd_data[g]),
      .rd_vld(rd_vld[g]), .busy(busy[g]),
      .underrun(underrun[g]),
      .mem_rd_en(mem_rd_en[g]),
      .mem_rd_addr(mem_rd_addr[g]),
      .mem_rd_data(mem_rd_data[g]),
      .chksum(chksum[g])
    );

    always @(posedge clk) begin
      if (mem_rd_en[g]) q1 <= memv[mem_rd_addr[g]];
      q2 <= q1;
    end

    always @(posedge clk or negedge rstn) begin
      if (!rstn)              cnt <= 0;
      else if (mem_rd_en[g])  cnt <= cnt + 1;
    end

    assign mem_rd_data[g] = (g == 0) ? q1 : q2;
    assign en_cnt[g]      = cnt;
  end

  task automatic chk(string tag, logic [31:0] got,
                     logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  function automatic logic [15:0] exp_word(int base, int k);
    int a;
    a = ((base & ~1) + 2 * k) % 8192;
    return {memv[(a + 1) % 8192], memv[a]};
  endfunction

  function automatic logic [15:0] exp_sum(logic [15:0] x);
`ifdef TRACE_RD_CHKSUM_EN
    return x;
`else
    return 16'h0;
`endif
  endfunction

  task automatic do_arm(int i, int s, int n);
    arm[i]        = 1'b1;
    start_addr[i] = 13'(s);
    len[i]        = 13'(n);
    step();
    arm[i] = 1'b0;
  endtask

  task automatic wait_vld(int i, output int cyc);
    cyc = 1;
    while (!rd_vld[i] && cyc < 60) begin
      step();
      cyc++;
    end
  endtask

  task automatic consume(int i);
    rd_req[i] = 1'b1;
    step();
    rd_req[i] = 1'b0;
  endtask

  task automatic run_txn(int i, int s, int n, int gmax);
    int          lat, nw, e0, cyc, gap;
    logic [15:0] x, w;
    lat = i + 1;
    nw  = (n > 4096) ? 4096 : n;
    x   = '0;
    e0  = en_cnt[i];
    do_arm(i, s, n);
    if (nw == 0) begin
      chk("len0_busy", busy[i], 0);
      chk("len0_vld", rd_vld[i], 0);
    end
    for (int k = 0; k < nw; k++) begin
      wait_vld(i, cyc);
      chk("latency", cyc, lat + 3);
      w = exp_word(s, k);
      chk("data", rd_data[i], w);
      gap = $urandom_range(gmax, 0);
      for (int j = 0; j < gap; j++) begin
        step();
        chk("hold", {rd_vld[i], mem_rd_en[i], rd_data[i]},
            {2'b10, w});
      end
      chk("busy_hold", busy[i], 1);
      consume(i);
      x ^= w;
      chk("vld_drop", rd_vld[i], 0);
      chk("busy_after", busy[i], (k < nw - 1) ? 1 : 0);
    end
    step();
    chk("idle_en", mem_rd_en[i], 0);
    chk("rd_count", en_cnt[i] - e0, 2 * nw);
    chk("chksum", chksum[i], exp_sum(x));
    chk("no_underrun", underrun[i], 0);
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    step();
    step();
    rstn = 1'b1;
  endtask

  task automatic directed(int i);
    int          cyc, lat;
    logic [15:0] w;
    lat = i + 1;
    do_reset();
    chk("rst_out",
        {rd_vld[i], busy[i], underrun[i], mem_rd_en[i]}, 0);
    chk("rst_data", {rd_data[i], chksum[i]}, 0);
    // underrun after reset, cleared by arm
    consume(i);
    chk("underrun_set", underrun[i], 1);
    chk("underrun_data", {rd_data[i], rd_vld[i]}, 0);
    chk("underrun_en", {mem_rd_en[i], busy[i]}, 0);
    do_arm(i, 'h100, 0);
    chk("underrun_clr", underrun[i], 0);
    chk("len0_idle", {busy[i], rd_vld[i]}, 0);
    // basic readout, then wrap
    run_txn(i, 'h0010, 3, 0);
    run_txn(i, 'h1FFE, 2, 2);
    // re-arm during ISSUE_HI of the first word
    do_arm(i, 'h0000, 4);
    step();
    arm[i]        = 1'b1;
    start_addr[i] = 13'h0040;
    len[i]        = 13'd1;
    step();
    arm[i] = 1'b0;
    wait_vld(i, cyc);
    chk("rearm_lat", cyc, lat + 3);
    chk("rearm_data", rd_data[i], 16'h4140);
    w = rd_data[i];
    consume(i);
    chk("rearm_done", {busy[i], rd_vld[i]}, 0);
    chk("rearm_sum", chksum[i], exp_sum(16'h4140));
    for (int j = 0; j < 6; j++) begin
      step();
      if (rd_vld[i] || busy[i]) break;
    end
    chk("rearm_stale", {busy[i], rd_vld[i], rd_data[i]},
        {2'b00, w});
    // reset in the middle of WAIT
    do_arm(i, 'h0010, 3);
    step();
    step();
    rstn = 1'b0;
    #1;
    chk("midrst_out",
        {rd_vld[i], busy[i], underrun[i], mem_rd_en[i]}, 0);
    chk("midrst_val",
        {rd_data[i], chksum[i], 3'b0, mem_rd_addr[i]}, 0);
    step();
    rstn = 1'b1;
    for (int j = 0; j < 6; j++) step();
    chk("midrst_quiet", {rd_vld[i], busy[i], rd_data[i]}, 0);
    run_txn(i, 'h0010, 3, 1);
  endtask

  task automatic random_phase(int i);
    int s, n;
    for (int t = 0; t < 25; t++) begin
      if ($urandom_range(3, 0) == 0) begin
        consume(i);
        chk("rnd_underrun", underrun[i], 1);
      end
      s = $urandom_range(8191, 0);
      n = $urandom_range(6, 0);
      run_txn(i, s, n, 3);
    end
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      arm[i]        = 1'b0;
      start_addr[i] = '0;
      len[i]        = '0;
      rd_req[i]     = 1'b0;
    end
    rstn = 1'b0;
    for (int j = 0; j < 8192; j++) memv[j] = 8'(j);
    step();
    for (int i = 0; i < 2; i++) directed(i);
    for (int j = 0; j < 8192; j++) memv[j] = 8'($urandom);
    for (int i = 0; i < 2; i++) random_phase(i);
    // oversized len is clamped to one full buffer
    run_txn(0, $urandom_range(8191, 0), 'h1FFF, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
